// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and constants for the fetch / next-PC stage and its helpers.
package fetch_pc_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // Conditional-branch flags exactly as the decoder raises them; beq rides along with the others.
  typedef struct packed {
    logic branch;
    logic nbranch;
    logic bgez;
    logic bgtz;
    logic blez;
    logic bltz;
  } br_flags_t;

  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_pc_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_pc_unit_branch_cond_eval.sv
// Combinational conditional-branch resolution from decoder flags and operand status.
module branch_cond_eval
  import fetch_pc_unit_pkg::*;
(
  input  br_flags_t   flags_i,
  input  logic        alu_zero_i,
  input  logic [31:0] rs_data_i,
  output logic        taken_o
);

  logic sign;
  logic zero;
  logic specific;

  assign sign     = rs_data_i[31];
  assign zero     = (rs_data_i == '0);
  // beq is only a fallback: the decoder keeps branch high for every conditional form.
  assign specific = flags_i.nbranch | flags_i.bgez | flags_i.bgtz | flags_i.blez | flags_i.bltz;

  assign taken_o = (flags_i.bgez    & ~sign)
                 | (flags_i.bltz    &  sign)
                 | (flags_i.bgtz    & ~sign & ~zero)
                 | (flags_i.blez    & (sign | zero))
                 | (flags_i.nbranch & ~alu_zero_i)
                 | (flags_i.branch  & ~specific & alu_zero_i);

endmodule

// File: rtl/fetch_pc_unit.sv
// Owns the PC, fetches over the imem req/ack bus and issues one instruction at a time.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fetch_pc_unit_if.master        imem,
  output logic [31:0]            instr_o,
  output logic                   instr_valid_o,
  output logic [31:0]            pc_o,
  output logic [31:0]            link_pc_o,
  input  logic                   stall_i,
  input  logic                   branch_i,
  input  logic                   nbranch_i,
  input  logic                   bgez_i,
  input  logic                   bgtz_i,
  input  logic                   blez_i,
  input  logic                   bltz_i,
  input  logic                   jmp_i,
  input  logic                   jal_i,
  input  logic                   jr_i,
  input  logic                   alu_zero_i,
  input  logic [31:0]            rs_data_i,
  output logic                   fetch_err_o,
  output logic                   halted_o
);

  localparam int unsigned CNT_W = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);

  fetch_state_e     state_q;
  logic [31:0]      pc_q;
  logic [31:0]      instr_q;
  logic             req_q;
  logic             valid_q;
  logic             err_q;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;

  br_flags_t        br_flags;
  logic             br_taken;
  logic [31:0]      pc4;
  logic [31:0]      br_tgt;
  logic [31:0]      j_tgt;
  logic [31:0]      next_pc_d;
  logic             misaligned;

  assign br_flags = '{branch:  branch_i,
                      nbranch: nbranch_i,
                      bgez:    bgez_i,
                      bgtz:    bgtz_i,
                      blez:    blez_i,
                      bltz:    bltz_i};

  branch_cond_eval u_branch_cond_eval (
    .flags_i    (br_flags),
    .alu_zero_i (alu_zero_i),
    .rs_data_i  (rs_data_i),
    .taken_o    (br_taken)
  );

  always_comb begin
    pc4       = pc_q + 32'd4;
    br_tgt    = pc4 + br_offset(instr_q[15:0]);
    j_tgt     = {pc4[31:28], instr_q[25:0], 2'b00};
    next_pc_d = pc4;
    if (jr_i) begin
      next_pc_d = rs_data_i;
    end else if (jmp_i || jal_i) begin
      next_pc_d = j_tgt;
    end else if (br_taken) begin
      next_pc_d = br_tgt;
    end
  end

  assign misaligned = |next_pc_d[1:0];

  // The request is registered, so the first FETCH cycle after reset only raises imem_req;
  // an ack is accepted (and the timeout counted) only while the request is actually out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (imem.imem_ack) begin
            instr_q <= imem.imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_ISSUE;
          end else if (cnt_q == CNT_LAST) begin
            req_q    <= 1'b0;
            err_q    <= 1'b1;
            halted_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= ST_HALT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_ISSUE: begin
          if (!stall_i) begin
            valid_q <= 1'b0;
            if (misaligned) begin
              err_q    <= 1'b1;
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end else begin
              pc_q    <= next_pc_d;
              req_q   <= 1'b1;
              state_q <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          req_q <= 1'b0;
        end
        default: begin
          req_q    <= 1'b0;
          valid_q  <= 1'b0;
          halted_q <= 1'b1;
          state_q  <= ST_HALT;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_o        = instr_q;
  assign instr_valid_o  = valid_q;
  assign pc_o           = pc_q;
  assign link_pc_o      = pc4;
  assign fetch_err_o    = err_q;
  assign halted_o       = halted_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed plus randomized checks of fetch_pc_unit against an instruction-level reference model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  localparam int unsigned F_BEQ  = 0;
  localparam int unsigned F_BNE  = 1;
  localparam int unsigned F_BGEZ = 2;
  localparam int unsigned F_BGTZ = 3;
  localparam int unsigned F_BLEZ = 4;
  localparam int unsigned F_BLTZ = 5;
  localparam int unsigned F_J    = 6;
  localparam int unsigned F_JAL  = 7;
  localparam int unsigned F_JR   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr, pc, link_pc, rs_data;
  logic        instr_valid, stall, alu_zero, fetch_err, halted;
  logic [8:0]  flags;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mpc;
  logic [31:0] minstr;
  bit          mhalted;

  fetch_pc_unit_if imem_bus ();

  fetch_pc_unit #(
    .RESET_PC     (RST_PC),
    .IMEM_TIMEOUT (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem_bus),
    .instr_o       (instr),
    .instr_valid_o (instr_valid),
    .pc_o          (pc),
    .link_pc_o     (link_pc),
    .stall_i       (stall),
    .branch_i      (flags[F_BEQ]),
    .nbranch_i     (flags[F_BNE]),
    .bgez_i        (flags[F_BGEZ]),
    .bgtz_i        (flags[F_BGTZ]),
    .blez_i        (flags[F_BLEZ]),
    .bltz_i        (flags[F_BLTZ]),
    .jmp_i         (flags[F_J]),
    .jal_i         (flags[F_JAL]),
    .jr_i          (flags[F_JR]),
    .alu_zero_i    (alu_zero),
    .rs_data_i     (rs_data),
    .fetch_err_o   (fetch_err),
    .halted_o      (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: ISA-level branch semantics on the signed value of rs.
  function automatic bit ref_taken(input logic [8:0] f, input bit az, input logic [31:0] rs);
    int v;
    bit specific;
    v = int'(signed'(rs));
    specific = f[F_BNE] | f[F_BGEZ] | f[F_BGTZ] | f[F_BLEZ] | f[F_BLTZ];
    return (f[F_BGEZ] && v >= 0) || (f[F_BLTZ] && v < 0) ||
           (f[F_BGTZ] && v > 0)  || (f[F_BLEZ] && v <= 0) ||
           (f[F_BNE] && !az)     || (f[F_BEQ] && !specific && az);
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] w,
                                           input logic [8:0] f, input bit az,
                                           input logic [31:0] rs);
    logic [31:0] seq;
    int off;
    seq = cur + 32'd4;
    off = int'(signed'(w[15:0])) * 4;
    if (f[F_JR]) return rs;
    if (f[F_J] || f[F_JAL]) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
    if (ref_taken(f, az, rs)) return seq + 32'(off);
    return seq;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem_bus.imem_ack = 1'b0;
    #2;
    check32("rst_pc", pc, RST_PC);
    check32("rst_addr", imem_bus.imem_addr, RST_PC);
    check1("rst_req", imem_bus.imem_req, 1'b0);
    check32("rst_instr", instr, 32'h0);
    check1("rst_valid", instr_valid, 1'b0);
    check1("rst_err", fetch_err, 1'b0);
    check1("rst_halted", halted, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    mpc = RST_PC;
    minstr = '0;
    mhalted = 0;
  endtask

  task automatic wait_req();
    int unsigned n = 0;
    while (imem_bus.imem_req !== 1'b1 && n < 4) begin
      step();
      n++;
    end
    check1("req_up", imem_bus.imem_req, 1'b1);
    check32("imem_addr", imem_bus.imem_addr, mpc);
  endtask

  task automatic fetch_instr(input logic [31:0] w, input int unsigned waits);
    wait_req();
    for (int unsigned i = 0; i < waits; i++) begin
      step();
      check1("req_held", imem_bus.imem_req, 1'b1);
      check1("wait_err", fetch_err, 1'b0);
    end
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = w;
    step();
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = $urandom();
    check1("issue_valid", instr_valid, 1'b1);
    check32("issue_instr", instr, w);
    check1("req_drop", imem_bus.imem_req, 1'b0);
    minstr = w;
  endtask

  task automatic issue_instr(input logic [8:0] f, input bit az, input logic [31:0] rs,
                             input int unsigned stalls);
    logic [31:0] exp;
    flags = f;
    alu_zero = az;
    rs_data = rs;
    stall = 1'b1;
    for (int unsigned i = 0; i < stalls; i++) begin
      step();
      check1("stall_valid", instr_valid, 1'b1);
      check32("stall_pc", pc, mpc);
      check32("stall_instr", instr, minstr);
    end
    stall = 1'b0;
    check32("link_pc", link_pc, mpc + 32'd4);
    exp = ref_next(mpc, minstr, f, az, rs);
    step();
    check1("post_valid", instr_valid, 1'b0);
    if (exp[1:0] != 2'b00) begin
      check1("mis_err", fetch_err, 1'b1);
      check1("mis_halted", halted, 1'b1);
      check32("mis_pc", pc, mpc);
      check1("mis_req", imem_bus.imem_req, 1'b0);
      mhalted = 1;
    end else begin
      check32("next_pc", pc, exp);
      check1("next_req", imem_bus.imem_req, 1'b1);
      check1("next_err", fetch_err, 1'b0);
      mpc = exp;
    end
    flags = 9'($urandom());
    stall = 1'($urandom());
    rs_data = $urandom();
  endtask

  task automatic run(input logic [31:0] w, input logic [8:0] f, input bit az,
                     input logic [31:0] rs, input int unsigned waits, input int unsigned stalls);
    fetch_instr(w, waits);
    issue_instr(f, az, rs, stalls);
  endtask

  task automatic nops_to(input logic [31:0] target);
    int unsigned n = 0;
    while (mpc != target && n < 16) begin
      run(32'h0000_0000, 9'h000, 1'b0, 32'h0, 0, 0);
      n++;
    end
    check32("nops_to", mpc, target);
  endtask

  initial begin
    logic [31:0] w, rs;
    logic [8:0]  f;
    int unsigned kind, waits, stalls;
    bit          az;

    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = '0;
    stall = 1'b0;
    flags = '0;
    alu_zero = 1'b0;
    rs_data = '0;
    #2;
    do_reset();

    // A stray ack in the first post-reset cycle, before the request is out, must be ignored.
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_bus.imem_ack = 1'b0;
    check1("late_ack_valid", instr_valid, 1'b0);
    check32("late_ack_instr", instr, 32'h0);

    run(32'h2408_0005, 9'h000, 1'b0, 32'h0, 0, 0);
    check32("tp_first_pc", pc, 32'h0000_3004);

    nops_to(32'h0000_3010);
    run(32'h1000_FFFC, 9'h001, 1'b1, 32'h0, 1, 0);
    check32("tp_beq_taken", pc, 32'h0000_3004);
    nops_to(32'h0000_3010);
    run(32'h1000_FFFC, 9'h001, 1'b0, 32'h0, 0, 0);
    check32("tp_beq_not", pc, 32'h0000_3014);

    run(32'h1C00_0010, 9'h009, 1'b1, 32'h0000_0000, 0, 0);
    check32("tp_bgtz_zero", pc, 32'h0000_3018);
    run(32'h1C00_0010, 9'h009, 1'b0, 32'h0000_0001, 0, 0);
    check32("tp_bgtz_one", pc, 32'h0000_305C);
    run(32'h1800_0004, 9'h011, 1'b0, 32'h8000_0000, 0, 0);
    check32("tp_blez_neg", pc, 32'h0000_3070);

    run(32'h0800_0C08, 9'h040, 1'b0, 32'h0, 0, 0);
    check32("tp_jmp", pc, 32'h0000_3020);
    fetch_instr(32'h0C00_0C10, 0);
    check32("tp_jal_link", link_pc, 32'h0000_3024);
    issue_instr(9'h080, 1'b0, 32'h0, 0);
    check32("tp_jal_pc", pc, 32'h0000_3040);
    run(32'h03E0_0008, 9'h100, 1'b0, 32'h0000_3042, 0, 0);
    check1("tp_jr_err", fetch_err, 1'b1);
    check1("tp_jr_halted", halted, 1'b1);
    check32("tp_jr_pc", pc, 32'h0000_3040);
    imem_bus.imem_ack = 1'b1;
    step();
    step();
    imem_bus.imem_ack = 1'b0;
    check1("halt_req", imem_bus.imem_req, 1'b0);
    check1("halt_sticky", fetch_err, 1'b1);
    check1("halt_valid", instr_valid, 1'b0);
    check32("halt_pc", pc, 32'h0000_3040);

    do_reset();
    wait_req();
    for (int unsigned i = 0; i < 15; i++) begin
      step();
      check1("to_wait_err", fetch_err, 1'b0);
      check1("to_wait_req", imem_bus.imem_req, 1'b1);
    end
    step();
    check1("to_err", fetch_err, 1'b1);
    check1("to_halted", halted, 1'b1);
    check1("to_req", imem_bus.imem_req, 1'b0);

    do_reset();
    run(32'h0000_0000, 9'h000, 1'b0, 32'h0, 15, 0);
    check1("to_edge_err", fetch_err, 1'b0);
    check32("to_edge_pc", pc, 32'h0000_3004);

    run(32'h1234_5678, 9'h000, 1'b0, 32'h0, 0, 3);
    check32("stall_done_pc", pc, 32'h0000_3008);

    wait_req();
    step();
    step();
    do_reset();
    check32("midrst_pc", pc, RST_PC);

    for (int n = 0; n < 300; n++) begin
      w = $urandom();
      kind = $urandom_range(0, 10);
      f = '0;
      if (kind == 1) f[F_BEQ] = 1'b1;
      else if (kind == 2) begin
        f[F_BNE] = 1'b1;
        f[F_BEQ] = 1'b1;
      end else if (kind >= 3 && kind <= 6) begin
        f[kind-1] = 1'b1;
        f[F_BEQ] = 1'b1;
      end else if (kind >= 7 && kind <= 9) f[kind-1] = 1'b1;
      else if (kind == 10) f = 9'($urandom());
      case ($urandom_range(0, 3))
        0: rs = 32'h0;
        1: rs = {1'b1, 31'($urandom())};
        2: rs = {1'b0, 31'($urandom_range(1, 3))};
        default: rs = $urandom();
      endcase
      if (f[F_JR] && $urandom_range(0, 7) != 0) rs[1:0] = 2'b00;
      az = 1'($urandom_range(0, 1));
      waits = ($urandom_range(0, 19) == 0) ? 15 : $urandom_range(0, 3);
      stalls = $urandom_range(0, 2);
      run(w, f, az, rs, waits, stalls);
      if (mhalted) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch and next-PC stage directly upstream of the main decoder; owns the PC, fetches from instruction memory over a req/ack handshake, and presents one instruction per issue cycle.
- Resolves next PC from decoder branch/jump flags plus ALU/register status.
- Supplies the link address for jal.
- Halts on a misaligned jump-register target.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IMEM_TIMEOUT, 16, maximum cycles to wait for imem_ack before flagging fetch_err.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request, held until ack.
- imem_addr  out  32  fetch address = pc.
- imem_ack  in  1  one-cycle data-valid strobe from instruction memory.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- instr  out  32  latched instruction to decoder (op = instr[31:26], br_div = instr[20:16]).
- instr_valid  out  1  high during the ISSUE cycle.
- pc  out  32  current PC.
- link_pc  out  32  pc+4, for jal write-back.
- stall  in  1  datapath hold; freezes ISSUE.
- branch, nbranch, bgez, bgtz, blez, bltz, jmp, jal, jr  in  1 each  decoder flags.
- alu_zero  in  1  ALU result == 0 (beq/bne compare).
- rs_data  in  32  rs register value (sign/zero tests, jr target).
- fetch_err  out  1  sticky: timeout or misaligned target.
- halted  out  1  FSM in HALT.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH.
  - imem_req=0, instr=0, instr_valid=0, fetch_err=0, halted=0.
  - Timeout counter=0.
  - Reset mid-handshake aborts the fetch; a late imem_ack after reset release is ignored unless imem_req is high.
- Per-state outputs:
  - FETCH: imem_req=1, imem_addr=pc.
  - ISSUE: instr_valid=1.
  - HALT: halted=1.
- FSM transitions:
  - FETCH: on imem_ack, latch instr=imem_rdata and go to ISSUE.
  - FETCH timeout:
    - Counter increments each FETCH cycle without ack.
    - At count IMEM_TIMEOUT-1 with no ack: fetch_err=1 and go to HALT.
    - Ack on that same cycle wins: no error.
  - ISSUE, stall=1: remain in ISSUE; pc and instr unchanged.
  - ISSUE, stall=0: pc <= next_pc and go to FETCH.
  - ISSUE, next_pc[1:0] != 0: pc unchanged, fetch_err=1, go to HALT.
  - HALT: terminal until reset; imem_req=0.
- Branch condition (combinational, evaluated in ISSUE); sign = rs_data[31], z = (rs_data==0):
  - bgez taken if !sign.
  - bltz taken if sign.
  - bgtz taken if !sign && !z.
  - blez taken if sign || z.
  - nbranch (bne) taken if !alu_zero.
  - branch (beq) taken if alu_zero, but only when none of bgez/bltz/bgtz/blez/nbranch is high.
  - Decoder asserts branch alongside those flags, so the specific flag takes priority.
- Next-PC arithmetic:
  - pc4 = pc+4; all arithmetic is 32-bit and wraps modulo 2^32.
  - br_tgt = pc4 + (sext(instr[15:0]) << 2).
  - j_tgt = {pc4[31:28], instr[25:0], 2'b00}.
- Next-PC priority, highest first: jr -> rs_data; jmp or jal -> j_tgt; taken branch -> br_tgt; else pc4.
- Alignment and link:
  - Only jr can produce a misaligned target.
  - link_pc = pc4 combinationally.
  - No delay slot.
- Latency:
  - Minimum 2 cycles per instruction: 1 FETCH with immediate ack + 1 ISSUE.
  - Each ack wait cycle adds 1.

Decomposition:
- Shared package holds:
  - FSM state encoding: FETCH=2'd0, ISSUE=2'd1, HALT=2'd2.
  - Constant RESET_PC_DEFAULT.
  - Branch-flag bundle ordering.
- One sub-module: branch_cond_eval, purely combinational.
  - Inputs: flags, alu_zero, rs_data.
  - Output: taken.
  - Reused later by a pipelined variant.

Test Plan:
- Reset then immediate ack with rdata=32'h2408_0005 -> imem_addr=0x3000, instr_valid high next cycle, instr=0x24080005, after ISSUE pc=0x3004.
- beq, pc=0x3010, imm=0xFFFC, branch=1, alu_zero=1 -> next pc=0x3004; with alu_zero=0 -> 0x3014.
- bgtz with rs_data=0 -> not taken (pc+4); rs_data=1 -> taken; blez with rs_data=32'h8000_0000 -> taken, and branch=1 asserted alongside is ignored.
- jal at pc=0x3020, instr[25:0]=26'h0000C10 -> link_pc=0x3024, next pc=0x0000_3040; jr with rs_data=0x3042 -> fetch_err=1, halted=1, pc stays 0x3020-path value.
- No ack for 16 cycles -> fetch_err=1 on the 16th FETCH cycle, imem_req drops; ack on exactly the 16th cycle -> no error, normal ISSUE.
- stall=1 for 3 ISSUE cycles -> instr_valid held 3+1 cycles, pc constant; rst_n pulsed low mid-FETCH -> all outputs return to reset values asynchronously, pc=0x3000.
